mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_pkg.sv | 43 ++++
 rtl/mc_aludec.sv | 22 ++
 rtl/mc_control.sv | 156 +++++++++++++++
 tb/tb_mc_control.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPEEX,
    S_RTYPEWB,
    S_BEQEX,
    S_ADDIEX,
    S_ADDIWB,
    S_JEX,
    S_HALT,
    S_BNEEX
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU = 6'b101011;

  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b111;
  localparam logic [2:0] ALU_SLTU = 3'b011;

endpackage

// File: rtl/mc_aludec.sv
// R-type funct to ALU function decode; unmapped functs fall back to add.
module mc_aludec
  import mc_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    case (funct_i)
      FUNCT_ADD:  alucontrol_o = ALU_ADD;
      FUNCT_SUB:  alucontrol_o = ALU_SUB;
      FUNCT_AND:  alucontrol_o = ALU_AND;
      FUNCT_OR:   alucontrol_o = ALU_OR;
      FUNCT_SLT:  alucontrol_o = ALU_SLT;
      FUNCT_SLTU: alucontrol_o = ALU_SLTU;
      default:    alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM with sticky illegal-opcode flag.
// Optional bne support is enabled by defining MC_CONTROL_BNE_EN.
module mc_control
  import mc_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       pcwrite, branch, irwrite_s;
  logic [2:0] rtype_alu;
`ifdef MC_CONTROL_BNE_EN
  logic       bnebranch;
`endif

  mc_aludec u_aludec (
    .funct_i      (funct),
    .alucontrol_o (rtype_alu)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d    = S_FETCH;
    illegal_d  = illegal_q;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    irwrite_s  = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;
`ifdef MC_CONTROL_BNE_EN
    bnebranch  = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        state_d   = S_DECODE;
        irwrite_s = 1'b1;
        pcwrite   = 1'b1;
        alusrcb   = 2'b01;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef MC_CONTROL_BNE_EN
          OP_BNE:       state_d = S_BNEEX;
`endif
          default: begin
            illegal_d = 1'b1;
            state_d   = ILLEGAL_HALT ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        state_d = S_MEMWB;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        state_d    = S_RTYPEWB;
        alusrca    = 1'b1;
        alucontrol = rtype_alu;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
      end
`ifdef MC_CONTROL_BNE_EN
      S_BNEEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        bnebranch  = 1'b1;
      end
`endif
      S_ADDIEX: begin
        state_d = S_ADDIWB;
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset holds the FETCH decode visible but must not write PC or IR.
`ifdef MC_CONTROL_BNE_EN
  assign pcen = reset_n & (pcwrite | (branch & zero) | (bnebranch & ~zero));
`else
  assign pcen = reset_n & (pcwrite | (branch & zero));
`endif
  assign irwrite = reset_n & irwrite_s;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: two instances (halt / continue on illegal op).
module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op, funct;
  logic       zero;

  logic       a_pcen, a_iord, a_memwrite, a_irwrite, a_regdst, a_memtoreg, a_regwrite, a_alusrca, a_illegal;
  logic [1:0] a_alusrcb, a_pcsrc;
  logic [2:0] a_alucontrol;
  logic       b_pcen, b_iord, b_memwrite, b_irwrite, b_regdst, b_memtoreg, b_regwrite, b_alusrca, b_illegal;
  logic [1:0] b_alusrcb, b_pcsrc;
  logic [2:0] b_alucontrol;

  always #5 clk = ~clk;

  mc_control #(.ILLEGAL_HALT(1'b1)) u_dut_halt (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .pcen(a_pcen), .iord(a_iord), .memwrite(a_memwrite), .irwrite(a_irwrite),
    .regdst(a_regdst), .memtoreg(a_memtoreg), .regwrite(a_regwrite), .alusrca(a_alusrca),
    .alusrcb(a_alusrcb), .pcsrc(a_pcsrc), .alucontrol(a_alucontrol), .illegal(a_illegal)
  );

  mc_control #(.ILLEGAL_HALT(1'b0)) u_dut_cont (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .pcen(b_pcen), .iord(b_iord), .memwrite(b_memwrite), .irwrite(b_irwrite),
    .regdst(b_regdst), .memtoreg(b_memtoreg), .regwrite(b_regwrite), .alusrca(b_alusrca),
    .alusrcb(b_alusrcb), .pcsrc(b_pcsrc), .alucontrol(b_alucontrol), .illegal(b_illegal)
  );

  wire [15:0] act_a = {a_pcen, a_iord, a_memwrite, a_irwrite, a_regdst, a_memtoreg, a_regwrite,
                       a_alusrca, a_alusrcb, a_pcsrc, a_alucontrol, a_illegal};
  wire [15:0] act_b = {b_pcen, b_iord, b_memwrite, b_irwrite, b_regdst, b_memtoreg, b_regwrite,
                       b_alusrca, b_alusrcb, b_pcsrc, b_alucontrol, b_illegal};

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [5:0]  op;
    int          step;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [15:0] pk(input logic pc, io, mw, ir, rd, mr, rw, sa,
                                     input logic [1:0] sb, ps, input logic [2:0] alu,
                                     input logic ill);
    return {pc, io, mw, ir, rd, mr, rw, sa, sb, ps, alu, ill};
  endfunction

  function automatic logic [2:0] ref_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      6'b101011: return 3'b011;
      default:   return 3'b010;
    endcase
  endfunction

  // Cycles per instruction; 0 marks an opcode the controller does not decode.
  function automatic int cpi(input logic [5:0] o);
    case (o)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010: return 3;
`ifdef MC_CONTROL_BNE_EN
      6'b000101: return 3;
`endif
      default: return 0;
    endcase
  endfunction

  // Expected outputs in cycle i of a decoded instruction.
  function automatic logic [15:0] step_vec(input logic [5:0] o, f, input logic z,
                                           input int i, input logic ill);
    if (i == 0) return pk(1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, ill);
    if (i == 1) return pk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, ill);
    case (o)
      6'b100011, 6'b101011: begin
        if (i == 2) return pk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, ill);
        if (o == 6'b101011) return pk(0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, ill);
        if (i == 3) return pk(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, ill);
        return pk(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 3'b010, ill);
      end
      6'b000000: begin
        if (i == 2) return pk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, ref_alu(f), ill);
        return pk(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b010, ill);
      end
      6'b000100: return pk(z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, ill);
      6'b000101: return pk(~z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, ill);
      6'b001000: begin
        if (i == 2) return pk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, ill);
        return pk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010, ill);
      end
      default: return pk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010, ill);
    endcase
  endfunction

  localparam logic [15:0] RST_V  = 16'({8'b0, 2'b01, 2'b00, 3'b010, 1'b0});
  localparam logic [15:0] HALT_V = 16'({8'b0, 2'b00, 2'b00, 3'b010, 1'b1});

  task automatic chk(input string name, input logic [5:0] o, input int s,
                     input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s op=%b step=%0d got=%h exp=%h", name, o, s, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e_mon = exp_q.pop_front();
      chk("halt_inst", e_mon.op, e_mon.step, act_a, e_mon.a);
      chk("cont_inst", e_mon.op, e_mon.step, act_b, e_mon.b);
    end
  end

  task automatic push(input logic [15:0] va, vb, input logic [5:0] o, input int s);
    exp_t e;
    e.a = va; e.b = vb; e.op = o; e.step = s;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1 with the DUT in FETCH; k=0 runs the full instruction.
  task automatic issue(input logic [5:0] o, f, input logic z, input int k);
    int n;
    op = o; funct = f; zero = z;
    n = (k > 0) ? k : cpi(o);
    for (int i = 0; i < n; i++) begin
      if (cpi(o) != 0)
        push(step_vec(o, f, z, i, 1'b0), step_vec(o, f, z, i, 1'b0), o, i);
      else
        push((i < 2) ? step_vec(o, f, z, i, 1'b0) : HALT_V,
             step_vec(o, f, z, i % 2, i >= 2), o, i);
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    for (int i = 0; i < n; i++) push(RST_V, RST_V, 6'd0, -1);
    repeat (n) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  logic [5:0] functs[7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                            6'b101010, 6'b101011, 6'b111111};
  logic [5:0] ops[7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                         6'b001000, 6'b000010, 6'b000101};

  initial begin
    int guard;
    logic [5:0] ro, rf;
    reset_n = 1'b0; op = '0; funct = '0; zero = 1'b0;
    @(posedge clk); #1;
    do_reset(3);

    // lw interrupted in MEMRD by an asynchronous reset, then a full lw
    issue(6'b100011, 6'b0, 1'b0, 3);
    push(step_vec(6'b100011, 6'b0, 1'b0, 3, 1'b0), step_vec(6'b100011, 6'b0, 1'b0, 3, 1'b0), 6'b100011, 3);
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_halt", op, -1, act_a, RST_V);
    chk("async_rst_cont", op, -1, act_b, RST_V);
    push(RST_V, RST_V, 6'd0, -1);
    push(RST_V, RST_V, 6'd0, -1);
    repeat (3) @(posedge clk); #1;
    reset_n = 1'b1;
    issue(6'b100011, 6'b0, 1'b0, 0);

    foreach (functs[i]) issue(6'b000000, functs[i], 1'($urandom_range(0, 1)), 0);
    issue(6'b000100, 6'b0, 1'b1, 0);
    issue(6'b000100, 6'b0, 1'b0, 0);
    foreach (ops[i]) if (cpi(ops[i]) != 0) issue(ops[i], 6'($urandom), 1'($urandom_range(0, 1)), 0);

    issue(6'b111111, 6'b0, 1'b0, 12);
    do_reset(2);

    issue(6'b000101, 6'b0, 1'b0, (cpi(6'b000101) != 0) ? 0 : 4);
    if (cpi(6'b000101) == 0) do_reset(2);

    for (int n = 0; n < 60; n++) begin
      ro = ($urandom_range(0, 9) < 7) ? ops[$urandom_range(0, 6)] : 6'($urandom);
      rf = $urandom_range(0, 1) ? functs[$urandom_range(0, 6)] : 6'($urandom);
      if (cpi(ro) != 0) begin
        issue(ro, rf, 1'($urandom_range(0, 1)), 0);
      end else begin
        issue(ro, rf, 1'($urandom_range(0, 1)), $urandom_range(3, 6));
        do_reset(1);
      end
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
